// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - launches the mult/div unit, counts its latency and drives the Hi/Lo write enables
// A divide with a zero divisor skips the div unit and issues a one-cycle exception request.
module muldiv_sequencer #(
  parameter int MULT_CYCLES = 32,
  parameter int DIV_CYCLES  = 32,
  parameter int CNT_W       = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic op,
  input  logic divisor_zero,
  output logic mult_start,
  output logic div_start,
  output logic busy,
  output logic done,
  output logic hi_write,
  output logic lo_write,
  output logic sel_hilo_src,
  output logic div_zero_exc
);

  typedef enum logic [2:0] {IDLE, MULT_RUN, DIV_RUN, WRITE, EXC} state_t;

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state, state_next;
  logic [CNT_W-1:0] count, count_next;
  logic             first, first_next;
  logic             sel_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      count        <= '0;
      first        <= 1'b0;
      sel_hilo_src <= 1'b0;
    end else begin
      state        <= state_next;
      count        <= count_next;
      first        <= first_next;
      sel_hilo_src <= sel_next;
    end
  end

  // first marks the opening cycle of a run state so the unit start pulse lasts one cycle
  always_comb begin
    state_next   = state;
    count_next   = count;
    first_next   = 1'b0;
    sel_next     = sel_hilo_src;
    mult_start   = 1'b0;
    div_start    = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    hi_write     = 1'b0;
    lo_write     = 1'b0;
    div_zero_exc = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (!op) begin
            state_next = MULT_RUN;
            count_next = MULT_LOAD;
            first_next = 1'b1;
            sel_next   = 1'b0;
          end else if (!divisor_zero) begin
            state_next = DIV_RUN;
            count_next = DIV_LOAD;
            first_next = 1'b1;
            sel_next   = 1'b1;
          end else begin
            state_next = EXC;
          end
        end
      end
      MULT_RUN, DIV_RUN: begin
        busy       = 1'b1;
        mult_start = first && (state == MULT_RUN);
        div_start  = first && (state == DIV_RUN);
        if (count == '0) state_next = WRITE;
        else             count_next = count - CNT_ONE;
      end
      WRITE: begin
        busy       = 1'b1;
        done       = 1'b1;
        hi_write   = 1'b1;
        lo_write   = 1'b1;
        state_next = IDLE;
      end
      EXC: begin
        busy         = 1'b1;
        div_zero_exc = 1'b1;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - directed checks of the mult/div sequencer, default and MULT_CYCLES=1 instances
module tb_muldiv_sequencer;

  logic clk = 1'b0;
  logic reset, start, op, divisor_zero;
  logic mult_start, div_start, busy, done, hi_write, lo_write, sel_hilo_src, div_zero_exc;
  logic start1, op1, divisor_zero1;
  logic mult_start1, div_start1, busy1, done1, hi_write1, lo_write1, sel_hilo_src1, div_zero_exc1;
  int   checks = 0;
  int   errors = 0;
  logic [6:0] exp_v;

  wire [6:0] obs  = {mult_start, div_start, busy, done, hi_write, lo_write, div_zero_exc};
  wire [6:0] obs1 = {mult_start1, div_start1, busy1, done1, hi_write1, lo_write1, div_zero_exc1};

  always #5 clk = ~clk;

  muldiv_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .divisor_zero(divisor_zero),
    .mult_start(mult_start), .div_start(div_start), .busy(busy), .done(done),
    .hi_write(hi_write), .lo_write(lo_write), .sel_hilo_src(sel_hilo_src),
    .div_zero_exc(div_zero_exc)
  );

  muldiv_sequencer #(.MULT_CYCLES(1), .DIV_CYCLES(3), .CNT_W(6)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .op(op1), .divisor_zero(divisor_zero1),
    .mult_start(mult_start1), .div_start(div_start1), .busy(busy1), .done(done1),
    .hi_write(hi_write1), .lo_write(lo_write1), .sel_hilo_src(sel_hilo_src1),
    .div_zero_exc(div_zero_exc1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = 1'b0; divisor_zero = 1'b0;
    start1 = 1'b0; op1 = 1'b0; divisor_zero1 = 1'b0;
    repeat (2) tick();
    checks++;
    if (obs !== 7'b0 || sel_hilo_src !== 1'b0) begin
      errors++;
      $display("FAIL reset outputs=%b sel=%b required 0000000 sel=0", obs, sel_hilo_src);
    end
    checks++;
    if (obs1 !== 7'b0 || sel_hilo_src1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_dut1 outputs=%b sel=%b required 0000000 sel=0", obs1, sel_hilo_src1);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_mult();
    start = 1'b1; op = 1'b0;
    for (int c = 1; c <= 36; c++) begin
      tick();
      start = 1'b0;
      exp_v = {c == 1, 1'b0, c <= 33, c == 33, c == 33, c == 33, 1'b0};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL mult cycle %0d outputs=%b required %b", c, obs, exp_v);
      end
      if (c == 33) begin
        checks++;
        if (sel_hilo_src !== 1'b0) begin
          errors++;
          $display("FAIL mult_sel got %b required 0", sel_hilo_src);
        end
      end
    end
  endtask

  task automatic test_div();
    start = 1'b1; op = 1'b1; divisor_zero = 1'b0;
    for (int c = 1; c <= 36; c++) begin
      tick();
      start = 1'b0;
      exp_v = {1'b0, c == 1, c <= 33, c == 33, c == 33, c == 33, 1'b0};
      checks++;
      if (obs !== exp_v || sel_hilo_src !== 1'b1) begin
        errors++;
        $display("FAIL div cycle %0d outputs=%b sel=%b required %b sel=1", c, obs, sel_hilo_src, exp_v);
      end
    end
  endtask

  task automatic test_div_zero();
    start = 1'b1; op = 1'b1; divisor_zero = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      start = 1'b0;
      exp_v = {1'b0, 1'b0, c == 1, 1'b0, 1'b0, 1'b0, c == 1};
      checks++;
      if (obs !== exp_v || sel_hilo_src !== 1'b1) begin
        errors++;
        $display("FAIL div_zero cycle %0d outputs=%b sel=%b required %b sel=1", c, obs, sel_hilo_src, exp_v);
      end
    end
    divisor_zero = 1'b0;
  endtask

  task automatic test_start_while_busy();
    start = 1'b1; op = 1'b0; divisor_zero = 1'b0;
    for (int c = 1; c <= 70; c++) begin
      tick();
      start = 1'b0;
      exp_v = {c == 1, c == 35, (c <= 33) || (c >= 35 && c <= 67),
               c == 33 || c == 67, c == 33 || c == 67, c == 33 || c == 67, 1'b0};
      checks++;
      if (obs !== exp_v || sel_hilo_src !== (c >= 35)) begin
        errors++;
        $display("FAIL busy_start cycle %0d outputs=%b sel=%b required %b sel=%b",
                 c, obs, sel_hilo_src, exp_v, c >= 35);
      end
      if (c == 5 || c == 33 || c == 34) begin
        start = 1'b1; op = 1'b1;
      end
    end
  endtask

  task automatic test_reset_mid();
    start = 1'b1; op = 1'b1; divisor_zero = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      start = 1'b0;
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (obs !== 7'b0 || sel_hilo_src !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid outputs=%b sel=%b required 0000000 sel=0", obs, sel_hilo_src);
    end
    repeat (2) tick();
    reset = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      checks++;
      if (obs !== 7'b0) begin
        errors++;
        $display("FAIL after_abort cycle %0d outputs=%b required 0000000", c, obs);
      end
    end
    start = 1'b1; op = 1'b0;
    for (int c = 1; c <= 34; c++) begin
      tick();
      start = 1'b0;
      exp_v = {c == 1, 1'b0, c <= 33, c == 33, c == 33, c == 33, 1'b0};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL mult_after_reset cycle %0d outputs=%b required %b", c, obs, exp_v);
      end
    end
  endtask

  task automatic test_mult_one_cycle();
    start1 = 1'b1; op1 = 1'b0; divisor_zero1 = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      tick();
      start1 = 1'b0;
      exp_v = {c == 1, 1'b0, c <= 2, c == 2, c == 2, c == 2, 1'b0};
      checks++;
      if (obs1 !== exp_v || sel_hilo_src1 !== 1'b0) begin
        errors++;
        $display("FAIL mult_one cycle %0d outputs=%b sel=%b required %b sel=0", c, obs1, sel_hilo_src1, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_start_while_busy();
    test_reset_mid();
    test_mult_one_cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
